frame_writer: RTL and testbench

- Write-side counterpart of the VGA pixel fetch path: accepts a raster-ordered stream of 8-bit grayscale pixels and stores it into the shared image memory.
- The image memory holds one IMG_WIDTH x IMG_HEIGHT image, row-major, one pixel per 32-bit word at address BASE_ADDR + row*IMG_WIDTH + col.
- Sits between the image source (loader or processing core) and the memory port that the display side later reads.
- Generates addresses with counters (no multiplier), applies valid/ready flow control on both sides, and flags frames that terminate early or late.

---
 rtl/frame_writer_if.sv | 22 ++
 rtl/frame_writer.sv | 127 ++++++++++++
 tb/tb_frame_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_if.sv
// Pixel stream (source side) and memory write port (sink side) of the frame writer.
// The slave modport is the frame writer's view; master is the environment's view.
interface frame_writer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_ready;
  logic        mem_wren;
  logic [21:0] address;
  logic [31:0] wdata;

  modport slave (
    input  in_valid, in_data, in_last, mem_ready,
    output in_ready, mem_wren, address, wdata
  );

  modport master (
    output in_valid, in_data, in_last, mem_ready,
    input  in_ready, mem_wren, address, wdata
  );
endinterface

// File: rtl/frame_writer.sv
// Stores a raster-ordered 8-bit pixel stream into the word-per-pixel image memory,
// with counter-based addressing and frame-length checking against in_last.
module frame_writer #(
  parameter int IMG_WIDTH  = 300,
  parameter int IMG_HEIGHT = 300,
  parameter int BASE_ADDR  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           frame_err,
  frame_writer_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [21:0]   base_q, base_d;
  logic          mem_wren_q, mem_wren_d;
  logic [21:0]   address_q, address_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          frame_err_q, frame_err_d;

  logic in_ready_c;
  logic accept;
  logic last_pix;

  // A stalled write blocks new pixels; a completing write makes room for the next one.
  assign in_ready_c = (state_q == S_WRITE) && (!mem_wren_q || bus.mem_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    base_d      = base_q;
    mem_wren_d  = mem_wren_q;
    address_d   = address_q;
    wdata_d     = wdata_q;
    frame_err_d = frame_err_q;

    if (mem_wren_q && bus.mem_ready) mem_wren_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WRITE;
          row_d       = '0;
          col_d       = '0;
          base_d      = 22'(BASE_ADDR);
          frame_err_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (accept) begin
          mem_wren_d = 1'b1;
          address_d  = base_q;
          wdata_d    = {24'h0, bus.in_data};
          base_d     = base_q + 22'd1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_pix) begin
            state_d = S_FLUSH;
            if (!bus.in_last) frame_err_d = 1'b1;
          end else if (bus.in_last) begin
            // Early end of frame: keep this pixel, leave the rest unwritten.
            state_d     = S_FLUSH;
            frame_err_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (mem_wren_q && bus.mem_ready) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      base_q      <= '0;
      mem_wren_q  <= 1'b0;
      // NOTE: the write-port data registers are reset as well so the bus is quiet out of reset.
      address_q   <= '0;
      wdata_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      base_q      <= base_d;
      mem_wren_q  <= mem_wren_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.mem_wren = mem_wren_q;
  assign bus.address  = address_q;
  assign bus.wdata    = wdata_q;
  assign busy         = (state_q == S_WRITE) || (state_q == S_FLUSH);
  assign done         = (state_q == S_DONE);
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: a driver pushes the expected write per accepted pixel,
// a monitor pops and compares on every completed memory write.
module tb_frame_writer;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int BASE = 100;
  localparam int NPIX = W * H;
  localparam int TMO  = 200;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  pix;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, frame_err;

  frame_writer_if bus ();

  frame_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  wr_t exp_q[$];
  int writes_seen = 0;
  int stall_cnt = 0;
  bit rand_ready = 1'b0;
  int stall_addr = -1;
  int stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Memory model: random or always-ready, with an optional fixed stall on one address.
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_wren && (int'(bus.address) == stall_addr) && (stall_left > 0)) begin
        bus.mem_ready = 1'b0;
        stall_left--;
      end else begin
        bus.mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: every completed write must match the oldest expected write.
  initial begin
    bit          hold_pending;
    logic [21:0] hold_addr;
    logic [31:0] hold_data;
    wr_t         e;
    hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_wren", bus.mem_wren, 1'b1);
          check("hold_address", bus.address, hold_addr);
          check("hold_wdata", bus.wdata, hold_data);
        end
        hold_pending = 1'b0;
        if (bus.mem_wren) check("address_in_range", bus.address < 22'(BASE + NPIX), 1'b1);
        if (bus.mem_wren && !bus.mem_ready) begin
          check("stall_in_ready", bus.in_ready, 1'b0);
          stall_cnt++;
          hold_pending = 1'b1;
          hold_addr    = bus.address;
          hold_data    = bus.wdata;
        end
        if (bus.mem_wren && bus.mem_ready) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", bus.address, 22'h3FFFFF);
          end else begin
            e = exp_q.pop_front();
            check("write_address", bus.address, e.addr);
            check("write_data", bus.wdata, {24'h0, e.pix});
          end
        end
      end
    end
  end

  // One frame from the source's point of view. last_beat < 0 or >= NPIX means no in_last.
  task automatic run_frame(input int last_beat, input int restart_beat, input bit gaps,
                           input bit seq, input int abort_at, input bit chk_latency);
    int n_beats, w0, lat;
    bit acc, seen, exp_err;
    logic [7:0] d;
    wr_t e;
    n_beats = (last_beat >= 0 && last_beat < NPIX) ? last_beat + 1 : NPIX;
    exp_err = (last_beat != NPIX - 1);
    w0 = writes_seen;
    @(posedge clk);
    #1;
    start = 1'b1;
    for (int b = 0; b < n_beats; b++) begin
      if (b == abort_at) return;
      if (gaps && b > 0) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
      d = seq ? 8'(8'h10 + b) : 8'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = (b == last_beat);
      if (b == restart_beat) start = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < TMO && !acc; t++) begin
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (b == 0 && t == 0) check("no_accept_with_start", bus.in_ready, 1'b0);
        if (b == 0 && t == 1) begin
          check("err_cleared_by_start", frame_err, 1'b0);
          check("busy_in_frame", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (!acc) begin
        check("accept_timeout", acc, 1'b1);
        break;
      end
      e.addr = 22'(BASE + b);
      e.pix  = d;
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int t = 1; t <= TMO && !seen; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = t;
      end
    end
    check("done_pulse", seen, 1'b1);
    if (chk_latency) check("done_latency", lat, 2);
    check("frame_err", frame_err, exp_err);
    check("write_count", writes_seen - w0, n_beats);
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, sel, lb;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #3;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_mem_wren", bus.mem_wren, 1'b0);
    check("rst_address", bus.address, 22'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean back-to-back frame with exact done timing.
    run_frame(NPIX - 1, -1, 1'b0, 1'b1, -1, 1'b1);

    // Three-cycle stall on the write of address BASE+5.
    s0 = stall_cnt;
    stall_addr = BASE + 5;
    stall_left = 3;
    run_frame(NPIX - 1, -1, 1'b0, 1'b1, -1, 1'b0);
    check("stall_cycles", stall_cnt - s0, 3);
    stall_addr = -1;

    // Early in_last on the 7th beat, then missing in_last; the next start clears the error.
    run_frame(6, -1, 1'b0, 1'b1, -1, 1'b0);
    run_frame(-1, -1, 1'b0, 1'b1, -1, 1'b0);

    // Reset after five accepts drops the pending write and restarts cleanly.
    run_frame(NPIX - 1, -1, 1'b0, 1'b1, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    check("midrst_mem_wren", bus.mem_wren, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(NPIX - 1, -1, 1'b0, 1'b1, -1, 1'b0);

    // start during the frame at beat 6 must be ignored.
    run_frame(NPIX - 1, 6, 1'b0, 1'b1, -1, 1'b0);

    // Randomised frames: random data, source gaps, memory backpressure, in_last placement.
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      sel = $urandom_range(0, 4);
      if (sel <= 2) lb = NPIX - 1;
      else if (sel == 3) lb = -1;
      else lb = $urandom_range(0, NPIX - 2);
      run_frame(lb, (f % 3 == 0) ? int'($urandom_range(1, NPIX - 1)) : -1, 1'b1, 1'b0, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
